// File: rtl/sdram_arbiter.sv
// sdram_arbiter
// Shares the single sdram_controller port between three bus masters.
// In IDLE it picks a winner round-robin and latches that master's payload.
// In BUSY it holds sdram_req until sdram_ack, then returns to IDLE.
// It also limits outstanding reads per master, flags controller hangs,
// and flags read returns that nobody was waiting for.
//
// Parameters:
//   MAX_RD  - outstanding (acked, data not yet returned) reads per master, 1..3
//   TIMEOUT - BUSY cycles without sdram_ack before err_timeout sets (8-bit)
//
// Ports:
//   clock, reset (async, active-low)
//   mN_req/addr/write/byte_enable/wdata  - master N request and payload
//   mN_ack                               - sdram_ack gated by the grant for N
//   mN_rdata, mN_rdvalid                 - read return passthrough
//   sdram_req (one-hot), sdram_addr/write/byte_enable/wdata - controller side
//   sdram_ack, sdram_rdata, sdram_rdvalid                   - controller side
//   err_timeout, err_rdvalid             - sticky error flags
module sdram_arbiter #(
   parameter int MAX_RD  = 2,
   parameter int TIMEOUT = 255
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        m0_req,
   input  logic [25:0] m0_addr,
   input  logic        m0_write,
   input  logic [3:0]  m0_byte_enable,
   input  logic [31:0] m0_wdata,
   output logic        m0_ack,
   output logic [31:0] m0_rdata,
   output logic        m0_rdvalid,
   input  logic        m1_req,
   input  logic [25:0] m1_addr,
   input  logic        m1_write,
   input  logic [3:0]  m1_byte_enable,
   input  logic [31:0] m1_wdata,
   output logic        m1_ack,
   output logic [31:0] m1_rdata,
   output logic        m1_rdvalid,
   input  logic        m2_req,
   input  logic [25:0] m2_addr,
   input  logic        m2_write,
   input  logic [3:0]  m2_byte_enable,
   input  logic [31:0] m2_wdata,
   output logic        m2_ack,
   output logic [31:0] m2_rdata,
   output logic        m2_rdvalid,
   output logic [2:0]  sdram_req,
   output logic [25:0] sdram_addr,
   output logic        sdram_write,
   output logic [3:0]  sdram_byte_enable,
   output logic [31:0] sdram_wdata,
   input  logic        sdram_ack,
   input  logic [31:0] sdram_rdata,
   input  logic [2:0]  sdram_rdvalid,
   output logic        err_timeout,
   output logic        err_rdvalid
);

   localparam logic [7:0] TO_LIM = 8'(TIMEOUT);
   localparam logic [1:0] RD_LIM = 2'(MAX_RD);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t      state;
   logic [2:0]  grant;
   logic [1:0]  ptr;
   logic [7:0]  to_cnt;
   logic [1:0]  rd_cnt [3];

   logic [2:0]  req_v;
   logic [2:0]  wr_v;
   logic [25:0] addr_v  [3];
   logic [3:0]  be_v    [3];
   logic [31:0] wdata_v [3];

   logic [2:0]  elig;
   logic [2:0]  rd_acc;
   logic        win_found;
   logic [1:0]  win_idx;

   assign req_v      = {m2_req, m1_req, m0_req};
   assign wr_v       = {m2_write, m1_write, m0_write};
   assign addr_v[0]  = m0_addr;
   assign addr_v[1]  = m1_addr;
   assign addr_v[2]  = m2_addr;
   assign be_v[0]    = m0_byte_enable;
   assign be_v[1]    = m1_byte_enable;
   assign be_v[2]    = m2_byte_enable;
   assign wdata_v[0] = m0_wdata;
   assign wdata_v[1] = m1_wdata;
   assign wdata_v[2] = m2_wdata;

   // grant is only non-zero in BUSY, so acks seen in IDLE fall through here
   assign m0_ack     = sdram_ack & grant[0];
   assign m1_ack     = sdram_ack & grant[1];
   assign m2_ack     = sdram_ack & grant[2];
   assign sdram_req  = grant;

   assign m0_rdata   = sdram_rdata;
   assign m1_rdata   = sdram_rdata;
   assign m2_rdata   = sdram_rdata;
   assign m0_rdvalid = sdram_rdvalid[0];
   assign m1_rdvalid = sdram_rdvalid[1];
   assign m2_rdvalid = sdram_rdvalid[2];

   // A read accepted this cycle for the granted master
   assign rd_acc = grant & {3{sdram_ack & ~sdram_write}};

   function automatic logic [1:0] wrap3(input logic [2:0] v);
      return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
   endfunction

   always_comb begin
      for (int n = 0; n < 3; n++)
         elig[n] = req_v[n] & (wr_v[n] | (rd_cnt[n] < RD_LIM));
   end

   // Walk offsets from farthest to nearest so the candidate closest to ptr
   // is the one left standing.
   always_comb begin
      logic [1:0] cand;
      win_found = 1'b0;
      win_idx   = 2'd0;
      cand      = 2'd0;
      for (int i = 2; i >= 0; i--) begin
         cand = wrap3({1'b0, ptr} + 3'(i));
         if (elig[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state             <= IDLE;
         grant             <= 3'b000;
         ptr               <= 2'd0;
         to_cnt            <= 8'd0;
         err_timeout       <= 1'b0;
         err_rdvalid       <= 1'b0;
         sdram_addr        <= '0;
         sdram_write       <= 1'b0;
         sdram_byte_enable <= '0;
         sdram_wdata       <= '0;
         for (int n = 0; n < 3; n++) rd_cnt[n] <= 2'd0;
      end else begin
         case (state)
            IDLE: begin
               if (win_found) begin
                  sdram_addr        <= addr_v[win_idx];
                  sdram_write       <= wr_v[win_idx];
                  sdram_byte_enable <= be_v[win_idx];
                  sdram_wdata       <= wdata_v[win_idx];
                  grant             <= 3'b001 << win_idx;
                  ptr               <= (win_idx == 2'd2) ? 2'd0 : win_idx + 2'd1;
                  to_cnt            <= 8'd0;
                  state             <= BUSY;
               end
            end
            BUSY: begin
               if (sdram_ack) begin
                  grant <= 3'b000;
                  state <= IDLE;
               end else begin
                  // Saturate at the limit; the request keeps waiting
                  if (to_cnt != TO_LIM) to_cnt <= to_cnt + 8'd1;
                  if (to_cnt + 8'd1 == TO_LIM) err_timeout <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase

         // Accept and return in the same cycle cancel out
         for (int n = 0; n < 3; n++) begin
            if (rd_acc[n] && !sdram_rdvalid[n]) begin
               rd_cnt[n] <= rd_cnt[n] + 2'd1;
            end else if (sdram_rdvalid[n] && !rd_acc[n]) begin
               if (rd_cnt[n] == 2'd0) err_rdvalid <= 1'b1;
               else                   rd_cnt[n] <= rd_cnt[n] - 2'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_sdram_arbiter.sv
module tb_sdram_arbiter;

   localparam int MAX_RD = 2;
   localparam int TMO    = 6;
   localparam int NCYC   = 5000;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [2:0]  m_req   = '0;
   logic [2:0]  m_write = '0;
   logic [25:0] m_addr  [3];
   logic [3:0]  m_be    [3];
   logic [31:0] m_wdata [3];
   logic [2:0]  m_ack;
   logic [2:0]  m_rdvalid;
   logic [31:0] m_rdata [3];
   logic [2:0]  sdram_req;
   logic [25:0] sdram_addr;
   logic        sdram_write;
   logic [3:0]  sdram_byte_enable;
   logic [31:0] sdram_wdata;
   logic        sdram_ack     = 1'b0;
   logic [31:0] sdram_rdata   = '0;
   logic [2:0]  sdram_rdvalid = '0;
   logic        err_timeout;
   logic        err_rdvalid;

   always #5 clock = ~clock;

   sdram_arbiter #(.MAX_RD(MAX_RD), .TIMEOUT(TMO)) dut (
      .clock(clock), .reset(reset),
      .m0_req(m_req[0]), .m0_addr(m_addr[0]), .m0_write(m_write[0]),
      .m0_byte_enable(m_be[0]), .m0_wdata(m_wdata[0]),
      .m0_ack(m_ack[0]), .m0_rdata(m_rdata[0]), .m0_rdvalid(m_rdvalid[0]),
      .m1_req(m_req[1]), .m1_addr(m_addr[1]), .m1_write(m_write[1]),
      .m1_byte_enable(m_be[1]), .m1_wdata(m_wdata[1]),
      .m1_ack(m_ack[1]), .m1_rdata(m_rdata[1]), .m1_rdvalid(m_rdvalid[1]),
      .m2_req(m_req[2]), .m2_addr(m_addr[2]), .m2_write(m_write[2]),
      .m2_byte_enable(m_be[2]), .m2_wdata(m_wdata[2]),
      .m2_ack(m_ack[2]), .m2_rdata(m_rdata[2]), .m2_rdvalid(m_rdvalid[2]),
      .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_write(sdram_write),
      .sdram_byte_enable(sdram_byte_enable), .sdram_wdata(sdram_wdata),
      .sdram_ack(sdram_ack), .sdram_rdata(sdram_rdata), .sdram_rdvalid(sdram_rdvalid),
      .err_timeout(err_timeout), .err_rdvalid(err_rdvalid)
   );

   int n_vec = 0;
   int n_bad = 0;
   int cyc   = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, got, exp);
      end
   endtask

   // Reference model: who is being served, whose turn is next, how many
   // reads each master has in flight, and what the controller should see.
   bit          busy;
   int          w;
   int          ptr;
   int          waited;
   int          ack_lat;
   int          cnt [3];
   bit          e_to, e_rv;
   logic [25:0] l_addr;
   logic        l_write;
   logic [3:0]  l_be;
   logic [31:0] l_wdata;
   bit          pend   [3];
   bit          wdrawn [3];
   int          rdq [$];

   task automatic model_reset();
      busy = 0; w = 0; ptr = 0; waited = 0; ack_lat = 0;
      e_to = 0; e_rv = 0;
      l_addr = '0; l_write = 1'b0; l_be = '0; l_wdata = '0;
      for (int n = 0; n < 3; n++) begin
         cnt[n] = 0;
         if (wdrawn[n]) begin
            wdrawn[n] = 0;
            pend[n]   = 0;
            m_req[n]  = 1'b0;
         end
      end
   endtask

   task automatic new_payload(input int n);
      m_addr[n]  = 26'($urandom);
      m_be[n]    = 4'($urandom);
      m_wdata[n] = $urandom;
   endtask

   initial begin
      int  ack_m, r, win;
      bit  ack_rd;
      bit  inc [3];
      for (int n = 0; n < 3; n++) begin
         new_payload(n);
         pend[n] = 0; wdrawn[n] = 0;
      end
      model_reset();

      for (cyc = 0; cyc < NCYC; cyc++) begin
         @(negedge clock);
         if (reset == 1'b0 && cyc != 0) reset = 1'b1;

         // Reset at start and now and then mid-run, mostly while a request is in flight
         if (cyc == 0 || (busy && $urandom_range(0, 150) == 0) || $urandom_range(0, 800) == 0) begin
            reset         = 1'b0;
            sdram_ack     = 1'b0;
            sdram_rdvalid = 3'b000;
            model_reset();
            #1;
            check_val("rst_sdram_req", 32'(sdram_req), 32'd0);
            check_val("rst_sdram_addr", 32'(sdram_addr), 32'd0);
            check_val("rst_sdram_wdata", sdram_wdata, 32'd0);
            check_val("rst_m_ack", 32'(m_ack), 32'd0);
            check_val("rst_err_timeout", 32'(err_timeout), 32'd0);
            check_val("rst_err_rdvalid", 32'(err_rdvalid), 32'd0);
            continue;
         end

         // Masters: start new requests; the granted one sometimes walks away
         for (int n = 0; n < 3; n++) begin
            if (!pend[n]) begin
               m_req[n] = 1'b0;
               if ($urandom_range(0, 2) == 0) begin
                  pend[n]    = 1;
                  m_req[n]   = 1'b1;
                  m_write[n] = ($urandom_range(0, 2) == 0);
                  new_payload(n);
               end
            end else if (busy && w == n && !wdrawn[n] && $urandom_range(0, 7) == 0) begin
               wdrawn[n] = 1;
               m_req[n]  = 1'b0;
               m_write[n] = 1'($urandom);
               new_payload(n);
            end
         end

         // Controller: ack after the chosen latency; stray acks while idle
         sdram_ack = busy ? (waited >= ack_lat) : ($urandom_range(0, 3) == 0);
         ack_m  = (busy && sdram_ack) ? w : -1;
         ack_rd = (ack_m >= 0) && !l_write;

         // Controller read returns, plus the occasional stray one
         sdram_rdvalid = 3'b000;
         sdram_rdata   = $urandom;
         if (rdq.size() > 0 && $urandom_range(0, 3) == 0) begin
            r = rdq[0];
            if (!(ack_rd && ack_m == r && cnt[r] == 0)) begin
               void'(rdq.pop_front());
               sdram_rdvalid[r] = 1'b1;
            end
         end else if ($urandom_range(0, 200) == 0) begin
            r = $urandom_range(0, 2);
            if (cnt[r] == 0 && !(ack_rd && ack_m == r)) sdram_rdvalid[r] = 1'b1;
         end

         #1;
         check_val("sdram_req", 32'(sdram_req), busy ? (32'd1 << w) : 32'd0);
         check_val("sdram_addr", 32'(sdram_addr), 32'(l_addr));
         check_val("sdram_write", 32'(sdram_write), 32'(l_write));
         check_val("sdram_byte_enable", 32'(sdram_byte_enable), 32'(l_be));
         check_val("sdram_wdata", sdram_wdata, l_wdata);
         for (int n = 0; n < 3; n++) begin
            check_val($sformatf("m%0d_ack", n), 32'(m_ack[n]), 32'(ack_m == n));
            check_val($sformatf("m%0d_rdvalid", n), 32'(m_rdvalid[n]), 32'(sdram_rdvalid[n]));
            check_val($sformatf("m%0d_rdata", n), m_rdata[n], sdram_rdata);
         end
         check_val("err_timeout", 32'(err_timeout), 32'(e_to));
         check_val("err_rdvalid", 32'(err_rdvalid), 32'(e_rv));

         // Advance the model to the state after the coming edge
         for (int n = 0; n < 3; n++) inc[n] = 0;
         if (busy) begin
            if (sdram_ack) begin
               if (!l_write) begin
                  inc[w] = 1;
                  rdq.push_back(w);
               end
               pend[w]   = 0;
               wdrawn[w] = 0;
               busy      = 0;
            end else begin
               waited++;
               if (waited == TMO) e_to = 1;
            end
         end else begin
            win = -1;
            for (int k = 0; k < 3 && win < 0; k++) begin
               int c;
               c = (ptr + k) % 3;
               if (m_req[c] && (m_write[c] || cnt[c] < MAX_RD)) win = c;
            end
            if (win >= 0) begin
               busy    = 1;
               w       = win;
               l_addr  = m_addr[win];
               l_write = m_write[win];
               l_be    = m_be[win];
               l_wdata = m_wdata[win];
               ptr     = (win + 1) % 3;
               waited  = 0;
               ack_lat = ($urandom_range(0, 5) == 0) ? $urandom_range(5, 9) : $urandom_range(0, 3);
            end
         end
         for (int n = 0; n < 3; n++) begin
            if (sdram_rdvalid[n] && !inc[n]) begin
               if (cnt[n] == 0) e_rv = 1;
               else             cnt[n]--;
            end else if (inc[n] && !sdram_rdvalid[n]) begin
               cnt[n]++;
            end
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
